// File: rtl/calc_unit.sv
// Registered ALU with valid/ready handshake; MUL is a WIDTH-cycle shift-add.
// Define CALC_UNIT_MUL_EN to build the multiplier; otherwise op=111 reports flag_err.
`timescale 1ns/1ps

module calc_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_err
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t state;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_err;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [SHW-1:0]   shamt;

    // Single-cycle ops are evaluated straight from the accepted inputs.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        shamt   = op2[SHW-1:0];
        sum     = {1'b0, op1} + {1'b0, op2};
        diff    = {1'b0, op1} - {1'b0, op2};
        // Extra bit on each side catches the last bit shifted out.
        shl_ext = {1'b0, op1} << shamt;
        shr_ext = {op1, 1'b0} >> shamt;
        case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = ~diff[WIDTH];
                alu_v   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_AND: alu_res = op1 & op2;
            OP_OR:  alu_res = op1 | op2;
            OP_XOR: alu_res = op1 ^ op2;
            OP_SHL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            OP_MUL: begin
`ifdef CALC_UNIT_MUL_EN
                alu_err = 1'b0;
`else
                alu_err = 1'b1;
`endif
            end
            default: alu_err = 1'b1;
        endcase
    end

`ifdef CALC_UNIT_MUL_EN
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     acc_upper;
    logic [2*WIDTH-1:0] acc_next;

    // Multiplier sits in the low half and is consumed LSB first as the product shifts in.
    always_comb begin
        acc_upper = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_next  = {acc_upper, acc[WIDTH-1:1]};
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_v    <= 1'b0;
            flag_err  <= 1'b0;
`ifdef CALC_UNIT_MUL_EN
            acc       <= '0;
            mcand     <= '0;
            count     <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
`ifdef CALC_UNIT_MUL_EN
                        if (op == OP_MUL) begin
                            mcand <= op1;
                            acc   <= {{WIDTH{1'b0}}, op2};
                            count <= CW'(WIDTH);
                            state <= StBusy;
                        end else
`endif
                        begin
                            result    <= alu_res;
                            result_hi <= '0;
                            flag_c    <= alu_c;
                            flag_z    <= (alu_res == '0);
                            flag_v    <= alu_v;
                            flag_err  <= alu_err;
                            out_valid <= 1'b1;
                            state     <= StDone;
                        end
                    end
                end
                StBusy: begin
`ifdef CALC_UNIT_MUL_EN
                    acc   <= acc_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        result    <= acc_next[WIDTH-1:0];
                        result_hi <= acc_next[2*WIDTH-1:WIDTH];
                        flag_c    <= 1'b0;
                        flag_z    <= (acc_next[WIDTH-1:0] == '0);
                        flag_v    <= (acc_next[2*WIDTH-1:WIDTH] != '0);
                        flag_err  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end
`else
                    state    <= StIdle;
                    in_ready <= 1'b1;
`endif
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state     <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_unit.sv
// Scoreboard bench for calc_unit: stimulus pushes expected results, a monitor pops on transfer.
`timescale 1ns/1ps

module tb_calc_unit;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = 3'b000;
    logic [WIDTH-1:0] op1 = '0;
    logic [WIDTH-1:0] op2 = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_c;
    logic             flag_z;
    logic             flag_v;
    logic             flag_err;

    calc_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .flag_err  (flag_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] hi;
        logic [3:0]       flags;  // {c, z, v, err}
        int               id;
    } exp_t;

    exp_t sb[$];
    int   n_total  = 0;
    int   n_pass   = 0;
    int   n_issued = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic reset_vals(input string tag);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".result"},    32'(result),    32'd0);
        check({tag, ".result_hi"}, 32'(result_hi), 32'd0);
        check({tag, ".flags"},     32'({flag_c, flag_z, flag_v, flag_err}), 32'd0);
    endtask

    // Issue one op, push its expectation, and measure acceptance-to-out_valid latency.
    task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] er, input logic [WIDTH-1:0] eh,
                         input logic [3:0] ef, input int elat, input bit noise);
        int   guard;
        int   lat;
        exp_t e;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check($sformatf("op%0d.in_ready", n_issued), 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op       = o;
        op1      = a;
        op2      = b;
        e.res    = er;
        e.hi     = eh;
        e.flags  = ef;
        e.id     = n_issued;
        sb.push_back(e);
        n_issued++;
        @(posedge clk); #1;
        // Scramble inputs after acceptance; optionally keep in_valid high while busy.
        in_valid = noise;
        op       = 3'b000;
        op1      = WIDTH'($urandom);
        op2      = WIDTH'($urandom);
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat >= 5) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check($sformatf("op%0d.latency", e.id), 32'(lat), 32'(elat));
    endtask

    // Monitor: compare on every output transfer.
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
                check("scoreboard_has_entry", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    m = sb.pop_front();
                    check($sformatf("op%0d.result", m.id),    32'(result),    32'(m.res));
                    check($sformatf("op%0d.result_hi", m.id), 32'(result_hi), 32'(m.hi));
                    check($sformatf("op%0d.flags", m.id),
                          32'({flag_c, flag_z, flag_v, flag_err}), 32'(m.flags));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw;
        repeat (3) @(posedge clk);
        #1;
        reset_vals("rst_hold");
        rst = 1'b0;
        @(posedge clk); #1;
        reset_vals("after_rst");

        // op, a, b, result, result_hi, {c,z,v,err}, latency, noise
        do_op(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1100, 1, 1'b1);
        do_op(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0010, 1, 1'b0);
        do_op(3'b001, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b0000, 1, 1'b0);
        do_op(3'b001, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b1010, 1, 1'b0);
        do_op(3'b011, 16'h1200, 16'h0034, 16'h1234, 16'h0000, 4'b0000, 1, 1'b0);
        do_op(3'b100, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 4'b0100, 1, 1'b0);
        do_op(3'b101, 16'h8001, 16'h0001, 16'h0002, 16'h0000, 4'b1000, 1, 1'b0);
        do_op(3'b101, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 4'b0000, 1, 1'b0);
        do_op(3'b110, 16'h0003, 16'h0001, 16'h0001, 16'h0000, 4'b1000, 1, 1'b0);
        do_op(3'b110, 16'h8000, 16'h001F, 16'h0001, 16'h0000, 4'b0000, 1, 1'b0);
        do_op(3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 4'b0000, 1, 1'b0);

        // Reset pulse while idle must clear the held AND result.
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        reset_vals("rst_idle");
        @(posedge clk); #1;
        rst = 1'b0;

        // Backpressure: outputs hold, stray in_valid ignored, then back-to-back accept.
        out_ready = 1'b0;
        do_op(3'b100, 16'h00FF, 16'h0F0F, 16'h0FF0, 16'h0000, 4'b0000, 1, 1'b0);
        in_valid = 1'b1;
        op       = 3'b000;
        op1      = 16'h1111;
        op2      = 16'h2222;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d.out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d.in_ready", i),  32'(in_ready),  32'd0);
            check($sformatf("hold%0d.result", i),    32'(result),    32'h0FF0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release.in_ready",  32'(in_ready),  32'd1);
        check("release.out_valid", 32'(out_valid), 32'd0);
        do_op(3'b000, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 4'b0000, 1, 1'b0);

`ifdef CALC_UNIT_MUL_EN
        do_op(3'b111, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0010, WIDTH + 1, 1'b1);
        do_op(3'b111, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0010, WIDTH + 1, 1'b0);
        do_op(3'b111, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 4'b0100, WIDTH + 1, 1'b0);

        // Abort a MUL at its eighth cycle: no result may ever appear.
        @(posedge clk); #1;
        in_valid = 1'b1;
        op       = 3'b111;
        op1      = 16'h1234;
        op2      = 16'h0100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mul_abort.busy", 32'(in_ready), 32'd0);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        reset_vals("rst_busy");
        @(posedge clk); #1;
        rst = 1'b0;
        saw = 1'b0;
        repeat (WIDTH + 8) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) saw = 1'b1;
        end
        check("mul_abort.no_out_valid", 32'(saw), 32'd0);
        do_op(3'b010, 16'hFFFF, 16'h00FF, 16'h00FF, 16'h0000, 4'b0000, 1, 1'b0);
`else
        do_op(3'b111, 16'h1234, 16'h0100, 16'h0000, 16'h0000, 4'b0101, 1, 1'b1);
        do_op(3'b000, 16'h0010, 16'h0020, 16'h0030, 16'h0000, 4'b0000, 1, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
